sliders_debounce: RTL and testbench

SLIDERS_DEBOUNCE -- requirements
Module: sliders_debounce

---
 rtl/sliders_debounce_pkg.sv | 13 +
 rtl/sliders_debounce_bit.sv | 46 ++++
 rtl/sliders_debounce.sv | 53 +++++
 tb/tb_sliders_debounce.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/sliders_debounce_pkg.sv
// Shared constants for the slider debouncer: default slider count, debounce
// length, and the per-bit counter width derived from that length.
package sliders_pkg;

    localparam int SLIDERS_WIDTH       = 10;
    localparam int DEBOUNCE_CYCLES_DEF = 500000;

    // Counter holds 0..cycles-1, so ceil(log2(cycles)) bits are enough.
    function automatic int cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/sliders_debounce_bit.sv
// One slider channel: two-flop synchronizer, saturating stability counter and
// the accepted (stable) level. update_o flags the edge on which stable_o changes.
module debounce_bit
    import sliders_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_i,
    output logic stable_o,
    output logic update_o
);

    localparam int             CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;
    logic          mismatch, at_max;

    always_comb begin
        mismatch = sync_q[1] ^ stable_q;
        at_max   = (cnt_q == CNT_MAX);
        update_o = mismatch & at_max;
        // Any agreement with the stable level, or an accepted update, restarts the count.
        cnt_d    = (mismatch && !at_max) ? cnt_q + 1'b1 : '0;
        stable_d = update_o ? sync_q[1] : stable_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], raw_i};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/sliders_debounce.sv
// Debounces WIDTH slider switches and reports level changes as a single strobe
// plus a sticky per-bit change mask that software clears.
module sliders_debounce
    import sliders_pkg::*;
#(
    parameter int WIDTH           = SLIDERS_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic             change_pulse,
    output logic [WIDTH-1:0] change_mask,
    input  logic             clear_mask
);

    logic [WIDTH-1:0] update;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             pulse_q, pulse_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk      (clk),
            .reset_n  (reset_n),
            .raw_i    (sw_raw[i]),
            .stable_o (sw_stable[i]),
            .update_o (update[i])
        );
    end

    always_comb begin
        pulse_d = |update;
        // A fresh update survives a coincident clear.
        mask_d  = clear_mask ? update : (mask_q | update);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_q <= 1'b0;
            mask_q  <= '0;
        end else begin
            pulse_q <= pulse_d;
            mask_q  <= mask_d;
        end
    end

    assign change_pulse = pulse_q;
    assign change_mask  = mask_q;

endmodule

// File: tb/tb_sliders_debounce.sv
// Directed bench for sliders_debounce with DEBOUNCE_CYCLES=4: stimulus queues
// the expected cycle/level/mask of each change strobe, a monitor checks them.
module tb_sliders_debounce;

    localparam int W  = 10;
    localparam int DC = 4;
    localparam int LAT = 2 + DC;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] sw_raw = '0;
    logic [W-1:0] sw_stable;
    logic         change_pulse;
    logic [W-1:0] change_mask;
    logic         clear_mask = 1'b0;

    sliders_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sw_raw       (sw_raw),
        .sw_stable    (sw_stable),
        .change_pulse (change_pulse),
        .change_mask  (change_mask),
        .clear_mask   (clear_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic [W-1:0] st;
        logic [W-1:0] mk;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    bit   done  = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the head of the queue; an expectation
    // whose cycle has passed without a strobe is reported as missed.
    always @(negedge clk) begin
        if (!done) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                exp_t m;
                m = q.pop_front();
                chk("missed_pulse_cycle", cyc, m.cyc);
            end
            if (change_pulse) begin
                if (q.size() == 0) begin
                    chk("spurious_pulse", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("pulse_cycle", cyc, e.cyc);
                    chk("pulse_stable", int'(sw_stable), int'(e.st));
                    chk("pulse_mask", int'(change_mask), int'(e.mk));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_outputs(input string tag, input logic [W-1:0] st, input logic [W-1:0] mk,
                                 input logic pl);
        chk({tag, "_stable"}, int'(sw_stable), int'(st));
        chk({tag, "_mask"}, int'(change_mask), int'(mk));
        chk({tag, "_pulse"}, int'(change_pulse), int'(pl));
    endtask

    task automatic expect_change(input int at, input logic [W-1:0] st, input logic [W-1:0] mk);
        exp_t e;
        e.cyc = at;
        e.st  = st;
        e.mk  = mk;
        q.push_back(e);
    endtask

    initial begin
        int c;

        // Reset with all switches low
        tick(3);
        check_outputs("in_reset", 10'h000, 10'h000, 1'b0);
        reset_n = 1'b1;
        tick(8);
        check_outputs("after_reset", 10'h000, 10'h000, 1'b0);

        // Single bit rising and held
        c = cyc;
        sw_raw[0] = 1'b1;
        expect_change(c + LAT, 10'h001, 10'h001);
        tick(LAT - 1);
        chk("bit0_not_yet", int'(sw_stable), 10'h000);
        tick(5);
        check_outputs("bit0_settled", 10'h001, 10'h001, 1'b0);

        // Bouncing bit 3: 2-cycle halves never reach the count
        for (int i = 0; i < 10; i++) begin
            sw_raw[3] = ~sw_raw[3];
            tick(2);
        end
        c = cyc;
        sw_raw[3] = 1'b1;
        expect_change(c + LAT, 10'h009, 10'h009);
        tick(LAT + 4);
        check_outputs("bit3_settled", 10'h009, 10'h009, 1'b0);

        // 3-cycle glitch on bit 9 is filtered
        sw_raw[9] = 1'b1;
        tick(3);
        sw_raw[9] = 1'b0;
        tick(10);
        check_outputs("glitch9", 10'h009, 10'h009, 1'b0);

        // Clear the mask, then drop bit 0 so only bit 0 is marked
        clear_mask = 1'b1;
        tick(1);
        clear_mask = 1'b0;
        tick(1);
        chk("mask_cleared", int'(change_mask), 10'h000);
        c = cyc;
        sw_raw[0] = 1'b0;
        expect_change(c + LAT, 10'h008, 10'h001);
        tick(LAT + 3);
        check_outputs("bit0_fall", 10'h008, 10'h001, 1'b0);

        // Clear coinciding with bit 5 update: set wins, others clear
        c = cyc;
        sw_raw[5] = 1'b1;
        expect_change(c + LAT, 10'h028, 10'h020);
        tick(LAT - 1);
        clear_mask = 1'b1;
        tick(1);
        clear_mask = 1'b0;
        tick(4);
        check_outputs("clear_vs_set", 10'h028, 10'h020, 1'b0);

        // Reset mid-count on bit 2 discards the count; held levels re-debounce
        sw_raw[2] = 1'b1;
        tick(5);
        chk("bit2_pre_reset", int'(sw_stable), 10'h028);
        reset_n = 1'b0;
        tick(1);
        check_outputs("mid_reset", 10'h000, 10'h000, 1'b0);
        c = cyc;
        reset_n = 1'b1;
        expect_change(c + LAT, 10'h02C, 10'h02C);
        tick(LAT - 1);
        chk("post_reset_not_yet", int'(sw_stable), 10'h000);
        tick(6);
        check_outputs("post_reset", 10'h02C, 10'h02C, 1'b0);

        tick(2);
        chk("queue_empty", q.size(), 0);
        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: cyc %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
